multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
Multicycle sequencer for the MIPS-style 32-bit datapath. It replaces the single-cycle control unit and drives the same datapath, reworked for multicycle operation with an IR, shared memory and A/B/ALUOut registers. It decodes the 6-bit opcode from the IR and steps each instruction through fetch, decode, execute, memory and writeback states. A ready handshake stalls the sequence on the shared memory port, a watchdog traps on a memory timeout, and a counter tracks retired instructions.

Parameters:
CNT_W, 16, width of retired-instruction counter
TIMEOUT, 255, max cycles waiting on MemReady before trap; 0 disables watchdog

Ports:
Clock  in  1  system clock, rising edge
Reset_n  in  1  asynchronous active-low reset
Opcode  in  6  IR[31:26] from datapath
MemReady  in  1  memory has completed the current read/write this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU zero (BEQ)
IorD  out  1  0: memory address = PC, 1: ALUOut
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
IRWrite  out  1  IR load
MemToReg  out  1  writeback source: 1 MDR, 0 ALUOut
RegDst  out  1  1: rd, 0: rt
RegWrite  out  1  register file write
ALUSrcA  out  1  0: PC, 1: reg A
ALUSrcB  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
ALUOp  out  2  00 add, 01 sub, 10 funct-decoded, 11 opcode-decoded
PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
State  out  4  current state encoding, for debug/verification
Trap  out  1  illegal opcode or memory timeout; sticky
InstrCount  out  CNT_W  retired instructions, wraps

Behaviour:
- Reset (Reset_n low, async): State=FETCH(0), InstrCount=0, Trap=0, watchdog=0. PCWrite, IRWrite, RegWrite and MemWrite are forced 0 while reset is asserted. Other outputs show the FETCH decode. Reset mid-instruction aborts it with no further writes.
- Moore outputs are decoded from State. Only PCWrite and IRWrite in FETCH are Mealy: each is qualified by MemReady. All outputs not listed for a state are 0.
- States and outputs:
  - FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=MemReady. Stays while MemReady=0; goes to DECODE when MemReady=1.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=00. Branch on Opcode:
    - 100011/101011 -> MEM_ADDR
    - 000000 -> R_EXEC
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000/001100/001101/001010 -> I_EXEC
    - any other opcode -> TRAP
  - MEM_ADDR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEM_READ if the latched opcode is LW, MEM_WRITE if SW.
  - MEM_READ(3): MemRead=1, IorD=1. Holds until MemReady=1, then goes to MEM_WB.
  - MEM_WB(4): RegWrite=1, MemToReg=1, RegDst=0. Goes to FETCH.
  - MEM_WRITE(5): MemWrite=1, IorD=1, strobe held through the stall. Goes to FETCH on MemReady=1.
  - R_EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to R_WB.
  - R_WB(7): RegWrite=1, RegDst=1, MemToReg=0. Goes to FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Goes to FETCH.
  - JUMP(9): PCWrite=1, PCSource=10. Goes to FETCH.
  - I_EXEC(10): ALUSrcA=1, ALUSrcB=10, ALUOp=11. Goes to I_WB.
  - I_WB(11): RegWrite=1, RegDst=0, MemToReg=0. Goes to FETCH.
  - TRAP(12): all controls 0, Trap=1. Exits only on reset.
  - Encodings 13-15 go to TRAP.
- Opcode latch: the opcode is captured into an internal register in DECODE. Later states use the latched value, so IR changes after DECODE have no effect.
- Latency (cycles, zero-wait memory): R/I-type 4, LW 5, SW 4, BEQ 3, J 3. Each memory wait cycle adds 1.
- Watchdog:
  - Counts consecutive MemReady=0 cycles in FETCH, MEM_READ and MEM_WRITE, and clears on MemReady=1 or on leaving those states.
  - If it reaches TIMEOUT with MemReady still 0, the next state is TRAP.
  - If MemReady=1 arrives in the same cycle as the limit, completion wins.
- InstrCount increments by 1 on every transition into FETCH from MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP or I_WB. It wraps from 2^CNT_W-1 to 0 and never increments in TRAP.

Test Plan:
- Reset, then R-type (Opcode=000000) with MemReady=1 -> State 0,1,6,7,0; RegWrite=1 and RegDst=1 only in state 7; InstrCount=1.
- LW with MemReady low 3 cycles in MEM_READ -> State 0,1,2,3,3,3,3,4,0; MemRead=IorD=1 throughout state 3; MemToReg=RegWrite=1 in state 4; 8 cycles total.
- FETCH with MemReady=0 for 2 cycles -> IRWrite=PCWrite=0 for 2 cycles, both 1 in the MemReady cycle; SW then shows MemWrite held high until MemReady.
- Opcode=111111 in DECODE -> State=12 next cycle, Trap=1 sticky, all write enables 0, InstrCount frozen; assert Reset_n=0 asynchronously mid-clock -> State=0, Trap=0 immediately.
- TIMEOUT=4, MemReady held 0 in FETCH -> TRAP after the 4th wait cycle; repeat with MemReady=1 on that cycle -> DECODE, no trap.
- CNT_W=2, run 5 J instructions (000010) -> PCWrite=1, PCSource=10 in state 9; InstrCount 1,2,3,0,1.

Source files
------------

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle sequencer and the MIPS datapath/memory.
// Pure wiring, no latency.
// No backpressure of its own; memory stalls ride on MemReady.
interface multicycle_control_fsm_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       Opcode;
    logic             MemReady;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             MemToReg;
    logic             RegDst;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic [1:0]       PCSource;
    logic [3:0]       State;
    logic             Trap;
    logic [CNT_W-1:0] InstrCount;

    // Datapath side: supplies the IR opcode and memory completion, consumes controls.
    modport master (
        output Opcode, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
        input  MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
        input  State, Trap, InstrCount
    );

    // Sequencer side.
    modport slave (
        input  Opcode, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
        output MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
        output State, Trap, InstrCount
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control sequencer: fetch/decode/execute/memory/writeback with trap and retire count.
// Moore outputs decoded from the state register; FETCH PCWrite/IRWrite are combinational on MemReady.
// Memory states hold until MemReady; a watchdog traps after TIMEOUT consecutive not-ready cycles.
module multicycle_control_fsm #(
    parameter int          CNT_W   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                     Clock,
    input  logic                     Reset_n,
    multicycle_control_fsm_if.slave  bus
);
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        I_EXEC    = 4'd10,
        I_WB      = 4'd11,
        TRAP      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Watchdog wide enough to hold TIMEOUT itself; TIMEOUT of 0 keeps it idle.
    localparam int              WD_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIM = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t           state;
    logic [5:0]       op_q;
    logic [WD_W-1:0]  wd_cnt;
    logic [CNT_W-1:0] instr_cnt;
    logic             mem_wait_st;
    logic             wd_expire;

    // A stall cycle that would make TIMEOUT consecutive misses; MemReady in that cycle still completes.
    assign mem_wait_st = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);
    assign wd_expire   = (TIMEOUT != 0) && mem_wait_st && !bus.MemReady && (wd_cnt == WD_LIM);

    // Sequencer: next state, opcode latch, watchdog and retire counter.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= FETCH;
            op_q      <= '0;
            wd_cnt    <= '0;
            instr_cnt <= '0;
        end else begin
            if ((TIMEOUT != 0) && mem_wait_st && !bus.MemReady && !wd_expire)
                wd_cnt <= wd_cnt + WD_W'(1);
            else
                wd_cnt <= '0;

            case (state)
                FETCH: begin
                    if (bus.MemReady)   state <= DECODE;
                    else if (wd_expire) state <= TRAP;
                end
                DECODE: begin
                    op_q <= bus.Opcode;
                    case (bus.Opcode)
                        OP_LW, OP_SW:                      state <= MEM_ADDR;
                        OP_RTYPE:                          state <= R_EXEC;
                        OP_BEQ:                            state <= BRANCH;
                        OP_J:                              state <= JUMP;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state <= I_EXEC;
                        default:                           state <= TRAP;
                    endcase
                end
                MEM_ADDR: state <= (op_q == OP_SW) ? MEM_WRITE : MEM_READ;
                MEM_READ: begin
                    if (bus.MemReady)   state <= MEM_WB;
                    else if (wd_expire) state <= TRAP;
                end
                MEM_WRITE: begin
                    if (bus.MemReady) begin
                        state     <= FETCH;
                        instr_cnt <= instr_cnt + CNT_W'(1);
                    end else if (wd_expire) begin
                        state <= TRAP;
                    end
                end
                MEM_WB, R_WB, BRANCH, JUMP, I_WB: begin
                    state     <= FETCH;
                    instr_cnt <= instr_cnt + CNT_W'(1);
                end
                R_EXEC: state <= R_WB;
                I_EXEC: state <= I_WB;
                TRAP:   state <= TRAP;
                default: state <= TRAP;
            endcase
        end
    end

    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;

    // Control decode from the current state; FETCH load strobes wait for MemReady and are killed in reset.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        case (state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                pc_write  = bus.MemReady & Reset_n;
                ir_write  = bus.MemReady & Reset_n;
            end
            DECODE:    alu_src_b = 2'b11;
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
            end
            I_WB:    reg_write = 1'b1;
            default: ;
        endcase
    end

    assign bus.PCWrite     = pc_write;
    assign bus.PCWriteCond = pc_write_cond;
    assign bus.IorD        = i_or_d;
    assign bus.MemRead     = mem_read;
    assign bus.MemWrite    = mem_write;
    assign bus.IRWrite     = ir_write;
    assign bus.MemToReg    = mem_to_reg;
    assign bus.RegDst      = reg_dst;
    assign bus.RegWrite    = reg_write;
    assign bus.ALUSrcA     = alu_src_a;
    assign bus.ALUSrcB     = alu_src_b;
    assign bus.ALUOp       = alu_op;
    assign bus.PCSource    = pc_source;
    assign bus.State       = state;
    assign bus.Trap        = (state == TRAP);
    assign bus.InstrCount  = instr_cnt;
endmodule
